multicycle_controller: RTL and testbench

Control FSM for the multicycle RISC-V core: sequences one shared ALU, one unified instruction/data memory port and the register file across several clocks per instruction. It sits beside the multicycle datapath and drives every mux select and write enable from the latched instruction fields. It supports the same instruction subset as the single-cycle decoder: lw, sw, R-type, I-type ALU, beq and jal. Its ALU-control encoding is identical to that decoder's.

---
 rtl/multicycle_controller.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RISC-V core (lw, sw, R, I-ALU, beq, jal).
// Optional memory wait states are enabled by defining MC_CTRL_MEM_WAIT_EN.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     state_q, state_d, cur_s;
    logic       mem_ok;
    logic       pcupdate, branch;
    logic [1:0] aluop;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign mem_ok           = 1'b1;
    assign unused_mem_ready = mem_ready;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // While in reset the outputs decode as FETCH, with all enables masked off below.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        cur_s      = rst_n ? state_q : S_FETCH;
        state_d    = S_FETCH;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        adrsrc     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        case (cur_s)
            S_FETCH: begin
                irwrite   = mem_ok;
                pcupdate  = mem_ok;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                state_d   = mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = mem_ok ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                state_d  = mem_ok ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                alusrcb = 2'b00;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: regwrite = 1'b1;
            S_BEQ: begin
                alusrca = 2'b10;
                alusrcb = 2'b00;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
        if (!rst_n) begin
            state_d    = S_FETCH;
            pcupdate   = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign pcwrite = pcupdate | (branch & zero);
    assign state   = state_q;

    always_comb begin
        case (opcode)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // Subtract only for R-type with funct7b5 set; I-type addi never subtracts.
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = ({opcode[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected per-cycle control rows are
// queued when an instruction is driven and compared as the FSM steps through it.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal_op;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] res, asa, asb, imm;
        logic [2:0] aluc;
        logic       ill;
    } row_t;

    row_t sb_q[$];
    row_t obs;
    int   n_checks = 0;
    int   n_errors = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .resultsrc(resultsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc),
        .alucontrol(alucontrol), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = '{st: state, pcw: pcwrite, adr: adrsrc, mw: memwrite, irw: irwrite,
                   rw: regwrite, res: resultsrc, asa: alusrca, asb: alusrcb,
                   imm: immsrc, aluc: alucontrol, ill: illegal_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic row_t r(input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                               input logic [1:0] res, asa, asb, imm,
                               input logic [2:0] aluc, input logic ill);
        return '{st: st, pcw: pcw, adr: adr, mw: mw, irw: irw, rw: rw,
                 res: res, asa: asa, asb: asb, imm: imm, aluc: aluc, ill: ill};
    endfunction

    function automatic row_t fetch_row(input logic [1:0] imm);
        return r(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction

    function automatic row_t decode_row(input logic [1:0] imm, input logic ill);
        return r(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill);
    endfunction

    function automatic row_t reset_row(input logic [3:0] st, input logic [1:0] imm);
        return r(st, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction

    // Sample mid-cycle, then advance past the next rising edge.
    task automatic step(input string name, input int n);
        row_t exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                check($sformatf("%s[%0d] underflow", name, i), 32'd1, 32'd0);
            end else begin
                exp = sb_q.pop_front();
                check($sformatf("%s[%0d] st=%0d", name, i, exp.st), 32'(obs), 32'(exp));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    endtask

    task automatic do_lw();
        set_in(7'b0000011, 3'b010, 1'b1, 1'b1);
        sb_q.push_back(fetch_row(2'b00));
        sb_q.push_back(decode_row(2'b00, 0));
        sb_q.push_back(r(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        sb_q.push_back(r(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        sb_q.push_back(r(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        step("lw", 5);
    endtask

    task automatic do_sw();
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
        sb_q.push_back(fetch_row(2'b01));
        sb_q.push_back(decode_row(2'b01, 0));
        sb_q.push_back(r(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        sb_q.push_back(r(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        step("sw", 4);
    endtask

    task automatic do_alu(input string name, input logic itype, input logic [2:0] f3,
                          input logic f7, input logic [2:0] aluc);
        set_in(itype ? 7'b0010011 : 7'b0110011, f3, f7, 1'b1);
        sb_q.push_back(fetch_row(2'b00));
        sb_q.push_back(decode_row(2'b00, 0));
        sb_q.push_back(r(itype ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                         itype ? 2'b01 : 2'b00, 2'b00, aluc, 0));
        sb_q.push_back(r(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        step(name, 4);
    endtask

    task automatic do_beq(input logic z);
        set_in(7'b1100011, 3'b000, 1'b0, z);
        sb_q.push_back(fetch_row(2'b10));
        sb_q.push_back(decode_row(2'b10, 0));
        sb_q.push_back(r(4'd9, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
        step(z ? "beq_taken" : "beq_not_taken", 3);
    endtask

    task automatic do_jal();
        set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
        sb_q.push_back(fetch_row(2'b11));
        sb_q.push_back(decode_row(2'b11, 0));
        sb_q.push_back(r(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
        sb_q.push_back(r(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0));
        step("jal", 4);
    endtask

    task automatic do_illegal(input logic [6:0] op);
        set_in(op, 3'b000, 1'b0, 1'b1);
        sb_q.push_back(fetch_row(2'b00));
        sb_q.push_back(decode_row(2'b00, 1));
        step($sformatf("illegal_%b", op), 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;
        set_in(7'b0000011, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        sb_q.push_back(reset_row(4'd0, 2'b00));
        sb_q.push_back(reset_row(4'd0, 2'b00));
        step("reset", 2);
        rst_n = 1'b1;

        do_lw();
`ifdef MC_CTRL_MEM_WAIT_EN
        do_sw();
`else
        mem_ready = 1'b0;
        do_sw();
        mem_ready = 1'b1;
`endif
        do_alu("r_add", 1'b0, 3'b000, 1'b0, 3'b000);
        do_alu("r_sub", 1'b0, 3'b000, 1'b1, 3'b001);
        do_alu("r_slt", 1'b0, 3'b010, 1'b0, 3'b101);
        do_alu("r_or",  1'b0, 3'b110, 1'b0, 3'b011);
        do_alu("r_and", 1'b0, 3'b111, 1'b1, 3'b010);
        do_alu("r_sll", 1'b0, 3'b001, 1'b0, 3'b000);
        do_alu("i_addi_f7", 1'b1, 3'b000, 1'b1, 3'b000);
        do_alu("i_slti", 1'b1, 3'b010, 1'b0, 3'b101);
        do_beq(1'b1);
        do_beq(1'b0);
        do_jal();
        do_illegal(7'b0000000);
        do_illegal(7'b0110111);

        // Abort a lw in MEMREAD with a two-cycle reset.
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        sb_q.push_back(fetch_row(2'b00));
        sb_q.push_back(decode_row(2'b00, 0));
        sb_q.push_back(r(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        step("lw_pre_abort", 3);
        rst_n = 1'b0;
        sb_q.push_back(reset_row(4'd3, 2'b00));
        sb_q.push_back(reset_row(4'd0, 2'b00));
        step("abort_reset", 2);
        rst_n = 1'b1;
        do_jal();

`ifdef MC_CTRL_MEM_WAIT_EN
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
        mem_ready = 1'b0;
        sb_q.push_back(r(4'd0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
        step("fetch_wait", 1);
        mem_ready = 1'b1;
        sb_q.push_back(fetch_row(2'b01));
        sb_q.push_back(decode_row(2'b01, 0));
        sb_q.push_back(r(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        step("sw_wait_pre", 3);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            sb_q.push_back(r(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        step("memwrite_wait", 3);
        mem_ready = 1'b1;
        sb_q.push_back(r(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        step("memwrite_done", 1);
`endif
        do_lw();

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
